bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Grants ownership of the shared serial data bus to one of several masters at a time, so that only one master drives the address/data phases seen by the slaves. Sits between the master request lines and the bus, monitors the slaves' shared `slave_busy` line, and enforces a one-cycle turnaround between owners. A hold-time watchdog revokes ownership from a master that never releases the bus.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters, ≥2.
- `MAX_HOLD`, 256: maximum cycles one master may own the bus; 0 disables the watchdog.
- `clk`  input  1  bus clock, all logic on rising edge.
- `rstn`  input  1  asynchronous active-low reset.
- `req`  input  NUM_MASTERS  per-master bus request, level; held high for the whole transaction.
- `slave_busy`  input  1  high while an addressed slave is still completing a transaction.
- `grant`  output  NUM_MASTERS  one-hot ownership; all-zero when the bus is free.
- `grant_id`  output  $clog2(NUM_MASTERS)  index of current owner; 0 when `grant` is zero.
- `bus_busy`  output  1  high whenever `grant` is non-zero.
- `timeout_err`  output  1  one-cycle pulse when the watchdog revokes a grant.
- `timeout_id`  output  $clog2(NUM_MASTERS)  index of the revoked master; holds until the next timeout.

## Operation
- Reset: state IDLE; `grant`, `grant_id`, `bus_busy`, `timeout_err`, `timeout_id` = 0; hold counter 0; RR pointer = NUM_MASTERS-1; penalty mask 0.
- Eligible set = `req & ~penalty_mask`.
- IDLE: if the eligible set is non-zero, pick the winner, load `grant`/`grant_id` and go to OWNED; hold counter cleared.
- OWNED: hold counter increments each cycle, saturating.
  - `req[owner]`=0 and `slave_busy`=0: clear grant, go to TURNAROUND.
  - `req[owner]`=0 and `slave_busy`=1: keep grant; stay in OWNED until `slave_busy` falls.
  - MAX_HOLD≠0 and counter reaches MAX_HOLD-1: clear grant, pulse `timeout_err`, latch `timeout_id`, set `penalty_mask[owner]`, go to TURNAROUND. The watchdog has priority over a simultaneous release.
- TURNAROUND: `grant` = 0 for exactly this cycle; arbitrate over the eligible set. Go to OWNED with the winner if one exists, else to IDLE.
- `penalty_mask[i]` clears on any cycle where `req[i]`=0.
- Winner selection: see Configuration. With RR enabled, the pointer updates to the winner index on every grant.
- Requests that rise or fall while another master owns the bus do not affect `grant`.
- Asynchronous reset mid-transaction drops `grant` immediately. No cleanup cycle is inserted.

## Timing
- Grant latency from IDLE: a `req` sampled high at edge N gives `grant` valid after edge N.
- Release to next grant: release sampled at edge N gives `grant`=0 after N and the next owner's `grant` after N+1. The gap is exactly one cycle.
- Maximum ownership: MAX_HOLD cycles of `grant` high. `timeout_err` is high in the first TURNAROUND cycle only.
- All outputs are registered. No combinational path runs from `req` to `grant`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. The search starts at pointer+1 and wraps modulo NUM_MASTERS; the first eligible master wins.
- Not defined: fixed priority, lowest index wins. The pointer register is not built. Master 0 can starve the others except where the watchdog intervenes.

## Structure
- Shared package `bus_pkg`:
  - arbiter state encoding (IDLE, OWNED, TURNAROUND);
  - `BUS_ID_W` = $clog2(NUM_MASTERS) helper;
  - the SID/ID width constant shared with the slaves.
- One sub-module `arb_pick`: combinational, takes the eligible vector and base index, returns a one-hot winner, its index and a valid flag. Fixed priority uses base 0.

## Test plan
- Reset, then `req`=4'b0000 for 10 cycles → `grant`=0, `bus_busy`=0, state IDLE.
- `req`=4'b0101 from IDLE → `grant`=4'b0001 one cycle later. Drop `req[0]` with `slave_busy`=0 → one zero-grant cycle, then `grant`=4'b0100.
- `ARB_ROUND_ROBIN_EN`, `req`=4'b1111 held, each owner releasing after 3 cycles → owners cycle 0,1,2,3,0. Without the macro, master 0 is re-granted whenever it re-requests.
- Owner drops `req` while `slave_busy`=1 for 5 cycles → `grant` held those 5 cycles, then the TURNAROUND cycle.
- MAX_HOLD=8, master 2 never releases, master 1 requesting → `grant` high exactly 8 cycles, `timeout_err` pulse with `timeout_id`=2, then `grant`=4'b0010. Master 2 is not re-granted until its `req` has been low for at least one cycle.
- Assert `rstn`=0 mid-ownership → `grant`=0 asynchronously. After release the arbiter is in IDLE and re-arbitrates normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, ID width helper and the
// slave ID width constant.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

  localparam int unsigned BUS_SID_W = 4;

  // Index width for n masters, never narrower than one bit
  function automatic int unsigned bus_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first set bit of i_elig starting at i_base,
// wrapping modulo N.
module arb_pick
  import bus_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = bus_id_w(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_base,
  output logic [N-1:0]  o_win_c,
  output logic [IW-1:0] o_idx_c,
  output logic          o_vld_c
);

  logic [IW-1:0] w_idx;

  always_comb begin
    w_idx   = '0;
    o_idx_c = '0;
    o_vld_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IW'((32'(i_base) + k) % N);
      if (!o_vld_c && i_elig[w_idx]) begin
        o_vld_c = 1'b1;
        o_idx_c = w_idx;
      end
    end
    o_win_c = o_vld_c ? (N'(1) << o_idx_c) : '0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared bus arbiter with one-cycle turnaround and hold-time watchdog.
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (lowest index).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  parameter  int unsigned MAX_HOLD    = 256,
  localparam int unsigned ID_W        = bus_id_w(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   bus_busy,
  output logic                   timeout_err,
  output logic [ID_W-1:0]        timeout_id
);

  localparam int unsigned HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit WDOG_EN = (MAX_HOLD != 0);

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [NUM_MASTERS-1:0] r_pen, w_pen_nxt, w_pen_set;
  logic [NUM_MASTERS-1:0] w_elig, w_win;
  logic [ID_W-1:0]        r_grant_id, w_grant_id_nxt;
  logic [ID_W-1:0]        r_tid, w_tid_nxt;
  logic [ID_W-1:0]        w_base, w_win_idx;
  logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
  logic                   r_bus_busy, r_terr, w_terr_nxt;
  logic                   w_win_vld, w_grant_evt, w_timeout, w_release;

  assign w_elig      = req & ~r_pen;
  assign w_grant_evt = (r_state != ARB_OWNED) && w_win_vld;
  assign w_timeout   = WDOG_EN && (r_hold == HOLD_LAST);
  assign w_release   = !req[r_grant_id] && !slave_busy;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;

  // Pointer tracks the most recent winner; search begins just after it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            r_ptr <= ID_W'(NUM_MASTERS - 1);
    else if (w_grant_evt) r_ptr <= w_win_idx;
  end

  assign w_base = ID_W'((32'(r_ptr) + 32'd1) % NUM_MASTERS);
`else
  assign w_base = '0;
`endif

  arb_pick #(
    .N  (NUM_MASTERS),
    .IW (ID_W)
  ) u_pick (
    .i_elig  (w_elig),
    .i_base  (w_base),
    .o_win_c (w_win),
    .o_idx_c (w_win_idx),
    .o_vld_c (w_win_vld)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_bus_busy <= 1'b0;
      r_terr     <= 1'b0;
      r_tid      <= '0;
      r_hold     <= '0;
      r_pen      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_bus_busy <= |w_grant_nxt;
      r_terr     <= w_terr_nxt;
      r_tid      <= w_tid_nxt;
      r_hold     <= w_hold_nxt;
      r_pen      <= w_pen_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_win_vld) w_state_nxt = ARB_OWNED;
      ARB_OWNED: if (w_timeout || w_release) w_state_nxt = ARB_TURN;
      ARB_TURN:  w_state_nxt = w_win_vld ? ARB_OWNED : ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs, hold counter and penalty mask
  always_comb begin
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_terr_nxt     = 1'b0;
    w_tid_nxt      = r_tid;
    w_hold_nxt     = r_hold;
    w_pen_set      = '0;
    case (r_state)
      ARB_OWNED: begin
        if (w_timeout) begin
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          w_terr_nxt     = 1'b1;
          w_tid_nxt      = r_grant_id;
          w_pen_set      = NUM_MASTERS'(1) << r_grant_id;
        end else if (w_release) begin
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
        end else if (r_hold != '1) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_grant_nxt    = w_win;
        w_grant_id_nxt = w_win_vld ? w_win_idx : '0;
        if (w_grant_evt) w_hold_nxt = '0;
      end
    endcase
    w_pen_nxt = (r_pen & req) | w_pen_set;
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign bus_busy    = r_bus_busy;
  assign timeout_err = r_terr;
  assign timeout_id  = r_tid;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus
// random traffic compared every cycle against a behavioural ownership model.
module tb_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] req = '0;
  logic         slave_busy = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id, timeout_id;
  logic         bus_busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .slave_busy  (slave_busy),
    .grant       (grant),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  // Model: who owns the bus, for how long, who is penalised
  int           m_owner = -1;
  int           m_hold  = 0;
  int           m_tid   = 0;
  bit           m_terr  = 1'b0;
  logic [N-1:0] m_pen   = '0;
`ifdef ARB_ROUND_ROBIN_EN
  int           m_ptr   = N - 1;
`endif

  function automatic int pick(input logic [N-1:0] e);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (e[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (e[i]) return i;
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    logic [N-1:0] elig, npen;
    int w;
    if (!rstn) begin
      m_owner = -1; m_hold = 0; m_tid = 0; m_terr = 1'b0; m_pen = '0;
`ifdef ARB_ROUND_ROBIN_EN
      m_ptr = N - 1;
`endif
    end else begin
      elig   = req & ~m_pen;
      npen   = m_pen & req;
      m_terr = 1'b0;
      if (m_owner >= 0) begin
        if (m_hold == MAXH - 1) begin
          npen[m_owner] = 1'b1;
          m_terr  = 1'b1;
          m_tid   = m_owner;
          m_owner = -1;
        end else if (!req[m_owner] && !slave_busy) begin
          m_owner = -1;
        end else begin
          m_hold++;
        end
      end else begin
        w = pick(elig);
        if (w >= 0) begin
          m_owner = w;
          m_hold  = 0;
`ifdef ARB_ROUND_ROBIN_EN
          m_ptr   = w;
`endif
        end
      end
      m_pen = npen;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [1:0]   eid;
    eg  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    n_vec++;
    if (grant !== eg) begin
      n_err++; $display("FAIL model grant t=%0t got %b want %b", $time, grant, eg);
    end
    if (grant_id !== eid) begin
      n_err++; $display("FAIL model grant_id t=%0t got %0d want %0d", $time, grant_id, eid);
    end
    if (bus_busy !== (m_owner >= 0)) begin
      n_err++; $display("FAIL model bus_busy t=%0t got %b want %b", $time, bus_busy, m_owner >= 0);
    end
    if (timeout_err !== m_terr) begin
      n_err++; $display("FAIL model timeout_err t=%0t got %b want %b", $time, timeout_err, m_terr);
    end
    if (timeout_id !== 2'(m_tid)) begin
      n_err++; $display("FAIL model timeout_id t=%0t got %0d want %0d", $time, timeout_id, m_tid);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt;
  int waited;
  int exp_own[5];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = '{0, 1, 2, 3, 0};
`else
    exp_own = '{0, 0, 0, 0, 0};
`endif
    cyc(2);
    rstn = 1'b1;
    chk("rst grant", grant, 0);
    chk("rst grant_id", grant_id, 0);
    chk("rst bus_busy", bus_busy, 0);
    chk("rst timeout_err", timeout_err, 0);
    chk("rst timeout_id", timeout_id, 0);
    cyc(10);
    chk("idle grant", grant, 0);
    chk("idle bus_busy", bus_busy, 0);

    // Grant, release, one-cycle gap, next owner
    req = 4'b0101;
    cyc(1); chk("first grant", grant, 4'b0001);
    chk("first busy", bus_busy, 1);
    req = 4'b0100;
    cyc(1); chk("gap grant", grant, 0);
    cyc(1); chk("second grant", grant, 4'b0100);
    chk("second grant_id", grant_id, 2);
    req = 4'b0000;
    cyc(1); chk("release grant", grant, 0);
    cyc(2);

    // Owner drops req while slave still busy
    req = 4'b0001;
    cyc(1); chk("busy own", grant, 4'b0001);
    req = 4'b0000; slave_busy = 1'b1;
    repeat (5) begin cyc(1); chk("busy hold", grant, 4'b0001); end
    slave_busy = 1'b0;
    cyc(1); chk("busy release", grant, 0);
    cyc(2);

    // Watchdog revokes master 2, master 1 takes over
    req = 4'b0100;
    cyc(1); chk("wdog own", grant, 4'b0100);
    req = 4'b0110;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (grant != 4'b0100) break;
      cnt++;
    end
    chk("wdog hold cycles", cnt, MAXH);
    chk("wdog grant off", grant, 0);
    chk("wdog timeout_err", timeout_err, 1);
    chk("wdog timeout_id", timeout_id, 2);
    cyc(1); chk("wdog next owner", grant, 4'b0010);
    chk("wdog pulse end", timeout_err, 0);
    chk("wdog id held", timeout_id, 2);
    req = 4'b0100;
    cyc(1); chk("penalty gap", grant, 0);
    cyc(3); chk("penalty blocks", grant, 0);
    req = 4'b0000;
    cyc(1); req = 4'b0100;
    cyc(1); chk("penalty cleared", grant, 4'b0100);
    req = 4'b0000;
    cyc(3);

    // Async reset mid-ownership
    req = 4'b0001;
    cyc(1); chk("pre-reset own", grant, 4'b0001);
    @(posedge clk); #2 rstn = 1'b0;
    #1 chk("async rst grant", grant, 0);
    chk("async rst busy", bus_busy, 0);
    cyc(1); req = 4'b0000;
    cyc(1); rstn = 1'b1;
    cyc(1);

    // All masters requesting, each owner releases after three cycles
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (grant == 0 && waited < 20) begin cyc(1); waited++; end
      if (grant == 0) begin
        n_vec++; n_err++;
        $display("FAIL rr wait expired k=%0d got grant %b want nonzero", k, grant);
      end
      chk("rr owner", grant_id, exp_own[k]);
      cyc(2);
      req[grant_id] = 1'b0;
      cyc(1);
      req = 4'b1111;
    end
    req = 4'b0000;
    cyc(3);

    // Random traffic with sticky requests
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      slave_busy = ($urandom_range(3) == 0);
    end
    req = '0; slave_busy = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
